// File: rtl/core_input_pio_capture.sv
// Avalon-MM input PIO: synchronised level register, edge capture (write-1-to-clear) and maskable irq.
// Optional per-bit debounce filter enabled by defining CORE_PIO_DEBOUNCE_EN.
module core_input_pio_capture #(
  parameter int WIDTH           = 18,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr;
  logic [1:0]       prime_reg;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef CORE_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A bit's level only follows sync2 after DEBOUNCE_CYCLES consecutive differing cycles.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_reg;
    logic             lvl_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
        lvl_reg <= 1'b0;
      end else if (sync2_reg[gi] == lvl_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        lvl_reg <= sync2_reg[gi];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign lvl[gi] = lvl_reg;
  end
`else
  assign lvl = sync2_reg;
`endif

  // Edges are masked until the pipeline has filled, so inputs high at reset never capture.
  always_comb begin
    case (EDGE_MODE)
      1:       edge_vec = ~lvl & prev_reg;
      2:       edge_vec = lvl ^ prev_reg;
      default: edge_vec = lvl & ~prev_reg;
    endcase
    if (prime_reg != 2'd3) edge_vec = '0;
  end

  assign clr               = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  assign edge_capture_next = (edge_capture_reg & ~clr) | edge_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg         <= '0;
      prime_reg        <= 2'd0;
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
    end else begin
      prev_reg         <= lvl;
      edge_capture_reg <= edge_capture_next;
      if (prime_reg != 2'd3) prime_reg <= prime_reg + 2'd1;
      if (wr_en && address == 2'd1) irq_mask_reg <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = lvl;
      2'd1:    readdata[WIDTH-1:0] = irq_mask_reg;
      2'd2:    readdata[WIDTH-1:0] = edge_capture_reg;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_core_input_pio_capture.sv
// Directed bench for core_input_pio_capture: three instances (rising, falling, any edge) share one bus.
`timescale 1ns/1ps
module tb_core_input_pio_capture;

  localparam int W = 18;
`ifdef CORE_PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 50000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  core_input_pio_capture #(.WIDTH(W), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DB)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r), .in_port(in_port), .irq(irq_r));

  core_input_pio_capture #(.WIDTH(W), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DB)) u_dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_f), .in_port(in_port), .irq(irq_f));

  core_input_pio_capture #(.WIDTH(W), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DB)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic peek(input logic [1:0] a);
    address = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifndef CORE_PIO_DEBOUNCE_EN
    // Reset with inputs already high: no spurious capture after release
    in_port = 18'h3FFFF;
    tick(3);
    peek(0); check_eq("rst_data", rd_r, 32'h0);
    check_eq("rst_irq", {31'd0, irq_r}, 32'h0);
    peek(2); check_eq("rst_capture", rd_r, 32'h0);
    reset = 1'b0;
    tick(10);
    peek(0); check_eq("init_data", rd_r, 32'h0003FFFF);
    peek(2); check_eq("init_cap_rise", rd_r, 32'h0);
    check_eq("init_cap_any", rd_a, 32'h0);
    check_eq("init_cap_fall", rd_f, 32'h0);
    check_eq("init_irq", {31'd0, irq_r}, 32'h0);
    peek(1); check_eq("init_mask", rd_r, 32'h0);

    // Falling edges on all bits
    in_port = '0;
    tick(5);
    peek(2); check_eq("fall_cap_rise", rd_r, 32'h0);
    check_eq("fall_cap_fall", rd_f, 32'h0003FFFF);
    check_eq("fall_cap_any", rd_a, 32'h0003FFFF);
    bus_write(2'd2, 32'hFFFFFFFF);
    peek(2); check_eq("clr_all_fall", rd_f, 32'h0);
    check_eq("clr_all_any", rd_a, 32'h0);

    // Rising edge on bit 0 with latency check
    bus_write(2'd1, 32'h1);
    in_port[0] = 1'b1;
    tick(1);
    peek(0); check_eq("lat_n_data", rd_r, 32'h0);
    check_eq("lat_n_irq", {31'd0, irq_r}, 32'h0);
    tick(1);
    peek(0); check_eq("lat_n1_data", rd_r, 32'h1);
    peek(2); check_eq("lat_n1_cap", rd_r, 32'h0);
    check_eq("lat_n1_irq", {31'd0, irq_r}, 32'h0);
    tick(1);
    check_eq("lat_n2_irq", {31'd0, irq_r}, 32'h1);
    peek(2); check_eq("lat_n2_cap", rd_r, 32'h1);
    check_eq("lat_n2_cap_any", rd_a, 32'h1);
    check_eq("lat_n2_cap_fall", rd_f, 32'h0);

    // Write-1-to-clear, then clear colliding with a new edge
    bus_write(2'd2, 32'h1);
    check_eq("w1c_irq", {31'd0, irq_r}, 32'h0);
    peek(2); check_eq("w1c_cap", rd_r, 32'h0);
    in_port[0] = 1'b0;
    tick(4);
    in_port[0] = 1'b1;
    tick(2);
    bus_write(2'd2, 32'h1);
    peek(2); check_eq("set_wins_cap", rd_r, 32'h1);
    check_eq("set_wins_irq", {31'd0, irq_r}, 32'h1);
    bus_write(2'd2, 32'h1);
    peek(2); check_eq("set_wins_clr", rd_r, 32'h0);

    // Masked capture, then unmask
    bus_write(2'd1, 32'h0);
    in_port[5] = 1'b1;
    tick(4);
    peek(2); check_eq("mask_cap", rd_r, 32'h20);
    check_eq("mask_irq_off", {31'd0, irq_r}, 32'h0);
    bus_write(2'd1, 32'h20);
    check_eq("mask_irq_on", {31'd0, irq_r}, 32'h1);
    peek(1); check_eq("mask_read", rd_r, 32'h20);

    // Writes to read-only and reserved addresses
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd3, 32'hFFFFFFFF);
    peek(0); check_eq("ro_data", rd_r, 32'h21);
    peek(1); check_eq("ro_mask", rd_r, 32'h20);
    peek(2); check_eq("ro_cap", rd_r, 32'h20);
    peek(3); check_eq("rsv_read", rd_r, 32'h0);

    // Asynchronous reset mid-cycle with pending captures
    bus_write(2'd2, 32'hFFFFFFFF);
    in_port = '0;
    tick(4);
    in_port = 18'h3;
    tick(4);
    peek(2); check_eq("pre_rst_cap", rd_r, 32'h3);
    bus_write(2'd1, 32'h3);
    check_eq("pre_rst_irq", {31'd0, irq_r}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_irq", {31'd0, irq_r}, 32'h0);
    peek(2); check_eq("async_rst_cap", rd_r, 32'h0);
    peek(1); check_eq("async_rst_mask", rd_r, 32'h0);
    peek(0); check_eq("async_rst_data", rd_r, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(10);
    peek(2); check_eq("prime_restart_cap", rd_r, 32'h0);
    check_eq("prime_restart_any", rd_a, 32'h0);
    peek(0); check_eq("prime_restart_data", rd_r, 32'h3);
`else
    // Debounce with an 8-cycle threshold
    tick(3);
    peek(0); check_eq("db_rst_data", rd_r, 32'h0);
    reset = 1'b0;
    tick(5);
    in_port[0] = 1'b1;
    tick(5);
    in_port[0] = 1'b0;
    tick(12);
    peek(0); check_eq("db_bounce_data", rd_r, 32'h0);
    peek(2); check_eq("db_bounce_cap", rd_r, 32'h0);
    in_port[0] = 1'b1;
    tick(9);
    peek(0); check_eq("db_hold_n8", rd_r, 32'h0);
    tick(1);
    check_eq("db_hold_n9", rd_r, 32'h1);
    tick(1);
    peek(2); check_eq("db_hold_cap", rd_r, 32'h1);
    tick(1);
    check_eq("db_one_cap", rd_r, 32'h1);
    check_eq("db_irq_masked", {31'd0, irq_r}, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
